fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/inst_package.sv | 32 +++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch.sv | 111 +++++++++++
 tb/tb_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_package.sv
// Shared instruction-set definitions: opcodes, the Nop fetch bundle, memory
// latency and the record types used by the fetch stage.
package inst_package;

   // Primary opcode field, bits [31:26] of each 32-bit instruction slot.
   typedef enum logic [5:0] {
      OPC_ALU    = 6'h00,
      OPC_LOAD   = 6'h01,
      OPC_STORE  = 6'h02,
      OPC_BRANCH = 6'h04,
      OPC_NOP    = 6'h13
   } opcode_t;

   // Instruction-memory read latency in cycles (enable to data).
   localparam int IMEM_LAT = 2;

   // Bundle presented to decode when nothing valid is queued: two Nop slots.
   localparam logic [63:0] NOP_BUNDLE = {OPC_NOP, 26'b0, OPC_NOP, 26'b0};

   // One fetch-queue entry: the bundle and the PC it was fetched from.
   typedef struct packed {
      logic [31:0] pc;
      logic [63:0] inst;
   } fq_entry_t;

   // One stage of the in-flight read pipe.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
   } inflight_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: synchronous FIFO of fetched bundles with flush, an occupancy
// count and a head view read straight from the storage array.
module fetch_fifo
   import inst_package::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush_i,
   input  logic             push_i,
   input  fq_entry_t        push_data_i,
   input  logic             pop_i,
   output logic [CNT_W-1:0] count_o,
   output fq_entry_t        head_o
);

   fq_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointer and count advance; depth is a power of two so pointers wrap freely.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
      count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
   end

   // Control registers: cleared by reset or flush.
   always_ff @(posedge clk) begin
      if (!rstn || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      // NOTE: the data array has no reset; count_q alone decides validity, so stale words are never presented.
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch.sv
// Instruction fetch: issues one 64-bit bundle read per cycle under a credit
// limit, tracks reads in flight, queues returned bundles and presents the head.
module fetch
   import inst_package::*;
#(
   parameter int          ADDR_W   = 15,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          FQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              interlock,
   input  logic              branch_flag,
   input  logic [31:0]       branch_pc,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [63:0]       imem_dout,
   output logic [31:0]       pc,
   output logic [63:0]       inst
);

   localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
   localparam int OCC_W = CNT_W + 1;

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   inflight_t        pipe_q [IMEM_LAT];
   inflight_t        pipe_d [IMEM_LAT];
   logic [OCC_W-1:0] inflight_cnt;
   logic [OCC_W-1:0] occupancy;
   logic             issue;

   logic [CNT_W-1:0] fq_count;
   fq_entry_t        fq_head;
   fq_entry_t        fq_wdata;
   logic             fq_nonempty;
   logic             fq_push;
   logic             fq_pop;
   logic             present;

   // Credit check: queued plus in-flight bundles must leave room for one more.
   always_comb begin
      // NOTE: blocking '=' accumulates inside combinational logic; registers below use '<=' only.
      inflight_cnt = '0;
      for (int i = 0; i < IMEM_LAT; i++) begin
         inflight_cnt = inflight_cnt + OCC_W'(pipe_q[i].valid);
      end
      occupancy = OCC_W'(fq_count) + inflight_cnt;
      issue     = rstn && !branch_flag && (occupancy < OCC_W'(FQ_DEPTH));
   end

   // Next fetch PC and in-flight pipe; a redirect kills everything in flight.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (branch_flag) begin
         fetch_pc_d = branch_pc;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + 32'd1;
      end

      pipe_d[0] = '{valid: issue, pc: fetch_pc_q};
      for (int i = 1; i < IMEM_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      if (branch_flag) begin
         for (int i = 0; i < IMEM_LAT; i++) begin
            pipe_d[i].valid = 1'b0;
         end
      end
   end

   // Fetch PC and in-flight pipe registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         fetch_pc_q <= RESET_PC;
         for (int i = 0; i < IMEM_LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pipe_q     <= pipe_d;
      end
   end

   assign imem_en   = issue;
   assign imem_addr = fetch_pc_q[ADDR_W-1:0];

   // The pipe exit lines up with the cycle its read data is on imem_dout.
   assign fq_wdata    = '{pc: pipe_q[IMEM_LAT-1].pc, inst: imem_dout};
   assign fq_push     = pipe_q[IMEM_LAT-1].valid && !branch_flag;
   assign fq_nonempty = (fq_count != '0);
   assign fq_pop      = fq_nonempty && !interlock && !branch_flag;

   fetch_fifo #(
      .DEPTH (FQ_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .flush_i     (branch_flag),
      .push_i      (fq_push),
      .push_data_i (fq_wdata),
      .pop_i       (fq_pop),
      .count_o     (fq_count),
      .head_o      (fq_head)
   );

   // Decode sees the queue head, or the Nop bundle when empty or in reset.
   assign present = rstn && fq_nonempty;
   assign pc      = present ? fq_head.pc   : 32'h0;
   assign inst    = present ? fq_head.inst : NOP_BUNDLE;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a default instance checked through a scoreboard of
// expected presented PCs plus cycle-exact checks, and a narrow-address instance
// starting near the top of its address space.
module tb_fetch;
   import inst_package::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        interlock = 1'b0;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_pc = 32'h0;

   logic        imem_en_a;
   logic [14:0] imem_addr_a;
   logic [63:0] imem_dout_a;
   logic [31:0] pc_a;
   logic [63:0] inst_a;

   logic        imem_en_b;
   logic [3:0]  imem_addr_b;
   logic [63:0] imem_dout_b;
   logic [31:0] pc_b;
   logic [63:0] inst_b;

   logic [63:0] rd1_a, rd2_a, rd1_b, rd2_b;

   int          errors = 0;
   int          checks = 0;
   int          cyc_n  = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   fetch dut_a (
      .clk         (clk),
      .rstn        (rstn),
      .interlock   (interlock),
      .branch_flag (branch_flag),
      .branch_pc   (branch_pc),
      .imem_en     (imem_en_a),
      .imem_addr   (imem_addr_a),
      .imem_dout   (imem_dout_a),
      .pc          (pc_a),
      .inst        (inst_a)
   );

   fetch #(
      .ADDR_W   (4),
      .RESET_PC (32'd14)
   ) dut_b (
      .clk         (clk),
      .rstn        (rstn),
      .interlock   (interlock),
      .branch_flag (branch_flag),
      .branch_pc   (branch_pc),
      .imem_en     (imem_en_b),
      .imem_addr   (imem_addr_b),
      .imem_dout   (imem_dout_b),
      .pc          (pc_b),
      .inst        (inst_b)
   );

   // Instruction memories: word k holds k, data two cycles after the enable.
   always @(posedge clk) begin
      rd1_a <= imem_en_a ? {49'b0, imem_addr_a} : 64'hBAD0_BAD0_BAD0_BAD0;
      rd2_a <= rd1_a;
      rd1_b <= imem_en_b ? {60'b0, imem_addr_b} : 64'hBAD0_BAD0_BAD0_BAD0;
      rd2_b <= rd1_b;
   end
   assign imem_dout_a = rd2_a;
   assign imem_dout_b = rd2_b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   // Scoreboard: a bundle consumed by decode must be the next expected PC.
   task automatic monitor();
      logic [31:0] e;
      if (rstn && (inst_a !== NOP_BUNDLE) && !interlock && !branch_flag) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_extra: observed pc=%0h expected no bundle (cycle %0d)", pc_a, cyc_n);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_pc", 64'(pc_a), 64'(e));
            check("sb_inst", inst_a, {49'b0, e[14:0]});
         end
      end
   endtask

   task automatic step(input logic rst_v, input logic il, input logic br, input logic [31:0] bpc);
      @(posedge clk);
      #1;
      rstn        = rst_v;
      interlock   = il;
      branch_flag = br;
      branch_pc   = bpc;
      cyc_n++;
      @(negedge clk);
      monitor();
   endtask

   initial begin
      // Initial reset.
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("reset_pc", 64'(pc_a), 64'h0);
      check("reset_inst", inst_a, NOP_BUNDLE);
      check("reset_en", 64'(imem_en_a), 64'h0);

      // Release, stream, then a 10-cycle interlock from cycle 5.
      for (int k = 0; k < 12; k++) exp_q.push_back(32'(k));
      cyc_n = -1;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("c0_en", 64'(imem_en_a), 64'h1);
      check("c0_addr", 64'(imem_addr_a), 64'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("c2_nop", inst_a, NOP_BUNDLE);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("c3_pc", 64'(pc_a), 64'h0);
      check("c3_inst", inst_a, 64'h0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("c4_pc", 64'(pc_a), 64'h1);
      check("c4_inst", inst_a, 64'h1);
      for (int c = 5; c <= 14; c++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         check("stall_pc", 64'(pc_a), 64'h2);
         check("stall_en", 64'(imem_en_a), (c == 5) ? 64'h1 : 64'h0);
      end
      repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
      check("stall_drained", 64'(exp_q.size()), 64'h0);

      // One-cycle reset with reads in flight, then a redirect at cycle 8.
      step(1'b0, 1'b0, 1'b0, 32'h0);
      check("midrst_pc", 64'(pc_a), 64'h0);
      check("midrst_inst", inst_a, NOP_BUNDLE);
      check("midrst_en", 64'(imem_en_a), 64'h0);
      exp_q.delete();
      for (int k = 0; k < 5; k++) exp_q.push_back(32'(k));
      cyc_n = -1;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("w_addr0", 64'(imem_addr_b), 64'd14);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("w_addr1", 64'(imem_addr_b), 64'd15);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("w_addr2", 64'(imem_addr_b), 64'd0);
      check("postrst_nop", inst_a, NOP_BUNDLE);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("w_addr3", 64'(imem_addr_b), 64'd1);
      check("postrst_pc", 64'(pc_a), 64'h0);
      for (int k = 0; k < 4; k++) begin
         if (k != 0) step(1'b1, 1'b0, 1'b0, 32'h0);
         check("w_pc", 64'(pc_b), 64'(14 + k));
         check("w_inst", inst_b, 64'((14 + k) % 16));
      end
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h100);
      check("br_hold_pc", 64'(pc_a), 64'h5);
      check("br_en", 64'(imem_en_a), 64'h0);
      check("br_consumed", 64'(exp_q.size()), 64'h0);
      for (int k = 0; k < 6; k++) exp_q.push_back(32'h100 + 32'(k));
      for (int c = 9; c <= 11; c++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         check("br_nop", inst_a, NOP_BUNDLE);
         check("br_nop_pc", 64'(pc_a), 64'h0);
         if (c == 9) check("br_target_addr", 64'(imem_addr_a), 64'h100);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("br_target_pc", 64'(pc_a), 64'h100);
      repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);

      // Fill the queue under interlock, then redirect with interlock still high.
      repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
      check("full_pc", 64'(pc_a), 64'h106);
      check("full_en", 64'(imem_en_a), 64'h0);
      step(1'b1, 1'b1, 1'b1, 32'h200);
      check("brfull_consumed", 64'(exp_q.size()), 64'h0);
      for (int k = 0; k < 3; k++) exp_q.push_back(32'h200 + 32'(k));
      repeat (3) begin
         step(1'b1, 1'b0, 1'b0, 32'h0);
         check("brfull_nop", inst_a, NOP_BUNDLE);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0);
      check("brfull_target", 64'(pc_a), 64'h200);
      repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
      check("final_drained", 64'(exp_q.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
